// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Package shared by the ALU, decode and the sequential
//                multiplier. It holds the ALU opcode encodings and the
//                multiplier FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   // ALU opcode encodings. 3'b111 is reserved.
   localparam logic [2:0] ALU_OP_AND = 3'b000;
   localparam logic [2:0] ALU_OP_ADD = 3'b001;
   localparam logic [2:0] ALU_OP_SUB = 3'b010;
   localparam logic [2:0] ALU_OP_SLT = 3'b011;
   localparam logic [2:0] ALU_OP_SRL = 3'b100;
   localparam logic [2:0] ALU_OP_SRA = 3'b101;
   localparam logic [2:0] ALU_OP_SLL = 3'b110;

   // Multiplier sequencing states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } mul_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Multicycle unsigned WIDTH x WIDTH -> 2*WIDTH shift-add
//                multiplier. It borrows the shared combinational ALU for
//                the per-bit accumulate: it drives alu_x/alu_y with ADD and
//                consumes alu_z plus the carry-out. It retires one multiplier
//                bit per cycle.
//                Optional build macro: ALU_MUL_EARLY_EXIT_EN. When it is
//                defined, the FSM finishes as soon as the remaining
//                multiplier bits are all zero. The pending shifts are
//                applied in a single step, so the result is unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] prod_hi,
   output logic [WIDTH-1:0] prod_lo,
   output logic [WIDTH-1:0] alu_x,
   output logic [WIDTH-1:0] alu_y,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_z,
   input  logic             alu_overflow
);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // 33-bit partial sum: ALU result with carry when the current bit is set.
   logic [WIDTH:0]     sum;
   // {hi,lo} after one right shift with the partial sum shifted in on top.
   logic [2*WIDTH-1:0] step;

   // State and datapath registers; async reset abandons any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         hi_q     <= '0;
         lo_q     <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state, datapath update and output decode
   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;

      ready    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      alu_x    = '0;
      alu_y    = '0;
      alu_op   = ALU_OP_ADD;
      prod_hi  = hi_q;
      prod_lo  = lo_q;

      sum  = mplier_q[0] ? {alu_overflow, alu_z} : {1'b0, hi_q};
      step = {sum, lo_q[WIDTH-1:1]};

      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               mcand_d  = a;
               mplier_d = b;
               hi_d     = '0;
               lo_d     = '0;
               cnt_d    = CNT_W'(WIDTH);
               state_d  = ITER;
            end
         end

         ITER: begin
            busy     = 1'b1;
            alu_x    = hi_q;
            alu_y    = mcand_q;
            {hi_d, lo_d} = step;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = DONE;
            end
`ifdef ALU_MUL_EARLY_EXIT_EN
            // No set bits left: the remaining cnt-1 iterations would only
            // shift right, so apply them in one step.
            if (mplier_d == '0) begin
               {hi_d, lo_d} = step >> (cnt_q - CNT_W'(1));
               state_d      = DONE;
            end
`endif
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule : alu_mul_seq
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mul_seq
//  Description : Self-checking bench for alu_mul_seq with a behavioural ALU
//                beside the DUT and a scoreboard of expected products.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        ready;
   logic        busy;
   logic        done;
   logic [31:0] prod_hi;
   logic [31:0] prod_lo;
   logic [31:0] alu_x;
   logic [31:0] alu_y;
   logic [2:0]  alu_op;
   logic [31:0] alu_z;
   logic        alu_overflow;
   logic [32:0] alu_sum;

   int          checks;
   int          errors;
   int          done_total;
   logic [63:0] exp_q[$];

   alu_mul_seq #(.WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .a            (a),
      .b            (b),
      .ready        (ready),
      .busy         (busy),
      .done         (done),
      .prod_hi      (prod_hi),
      .prod_lo      (prod_lo),
      .alu_x        (alu_x),
      .alu_y        (alu_y),
      .alu_op       (alu_op),
      .alu_z        (alu_z),
      .alu_overflow (alu_overflow)
   );

   // Behavioural model of the shared combinational ALU
   always_comb begin
      alu_sum      = '0;
      alu_z        = '0;
      alu_overflow = 1'b0;
      case (alu_op)
         3'b000: alu_z = alu_x & alu_y;
         3'b001: begin
            alu_sum      = {1'b0, alu_x} + {1'b0, alu_y};
            alu_z        = alu_sum[31:0];
            alu_overflow = alu_sum[32];
         end
         3'b010: alu_z = alu_x - alu_y;
         3'b011: alu_z = {31'b0, $signed(alu_x) < $signed(alu_y)};
         3'b100: alu_z = alu_x >> alu_y[4:0];
         3'b101: alu_z = $unsigned($signed(alu_x) >>> alu_y[4:0]);
         3'b110: alu_z = alu_x << alu_y[4:0];
         default: alu_z = '0;
      endcase
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_total++;
   end

   function automatic int exp_lat(input logic [31:0] mb);
      int lat;
      lat = 32;
`ifdef ALU_MUL_EARLY_EXIT_EN
      lat = 1;
      for (int i = 0; i < 32; i++) begin
         if (mb[i]) lat = i + 1;
      end
`endif
      return lat;
   endfunction

   // Present one operation while IDLE; returns at the negedge after the accept edge
   task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
      @(negedge clk);
      a     = ia;
      b     = ib;
      start = 1'b1;
      exp_q.push_back({32'b0, ia} * {32'b0, ib});
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   // Count edges after acceptance until done is seen; bounded
   task automatic wait_done(output int lat, output bit to, output int op_bad);
      lat    = 0;
      to     = 1'b1;
      op_bad = 0;
      while (lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (alu_op !== 3'b001) op_bad++;
         if (done === 1'b1) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags: ready=%b busy=%b done=%b, want 1 0 0", ready, busy, done);
      end
      checks++;
      if ({prod_hi, prod_lo} !== 64'd0 || alu_x !== 32'd0 || alu_y !== 32'd0) begin
         errors++;
         $display("FAIL reset_data: prod=%h x=%h y=%h, want zeros", {prod_hi, prod_lo}, alu_x, alu_y);
      end
      checks++;
      if (alu_op !== 3'b001) begin
         errors++;
         $display("FAIL reset_op: alu_op=%b, want 001", alu_op);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat; bit to; int bad; logic [63:0] exp;
      issue(32'd3, 32'd5);
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0 || alu_y !== 32'd3 || alu_x !== 32'd0) begin
         errors++;
         $display("FAIL basic_iter: busy=%b ready=%b x=%h y=%h, want 1 0 0 3", busy, ready, alu_x, alu_y);
      end
      wait_done(lat, to, bad);
      exp = exp_q.pop_front();
      checks++;
      if (to || lat != exp_lat(32'd5)) begin
         errors++;
         $display("FAIL basic_latency: got %0d (timeout=%b), want %0d", lat, to, exp_lat(32'd5));
      end
      checks++;
      if ({prod_hi, prod_lo} !== exp || prod_lo !== 32'd15) begin
         errors++;
         $display("FAIL basic_product: got %h, want %h", {prod_hi, prod_lo}, exp);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1 || {prod_hi, prod_lo} !== exp) begin
         errors++;
         $display("FAIL basic_after: done=%b ready=%b prod=%h, want 0 1 %h", done, ready, {prod_hi, prod_lo}, exp);
      end
   endtask

   task automatic test_max();
      int lat; bit to; int bad; logic [63:0] exp;
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, to, bad);
      exp = exp_q.pop_front();
      checks++;
      if (to || {prod_hi, prod_lo} !== exp || prod_hi !== 32'hFFFF_FFFE || prod_lo !== 32'h0000_0001) begin
         errors++;
         $display("FAIL max_product: got %h (timeout=%b), want %h", {prod_hi, prod_lo}, to, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_zero();
      int lat; bit to; int bad; logic [63:0] exp;
      issue(32'h1234_5678, 32'd0);
      wait_done(lat, to, bad);
      exp = exp_q.pop_front();
      checks++;
      if (to || lat != exp_lat(32'd0)) begin
         errors++;
         $display("FAIL zero_latency: got %0d (timeout=%b), want %0d", lat, to, exp_lat(32'd0));
      end
      checks++;
      if ({prod_hi, prod_lo} !== exp) begin
         errors++;
         $display("FAIL zero_product: got %h, want %h", {prod_hi, prod_lo}, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_start();
      int lat; bit to; int bad; int d0; logic [63:0] exp;
      d0 = done_total;
      issue(32'd7, 32'd9);
      a     = 32'd2;
      b     = 32'd2;
      start = 1'b1;
      exp_q.push_back(64'd4);
      wait_done(lat, to, bad);
      exp = exp_q.pop_front();
      checks++;
      if (to || lat != exp_lat(32'd9) || {prod_hi, prod_lo} !== exp) begin
         errors++;
         $display("FAIL ignore_first: lat=%0d prod=%h, want lat=%0d prod=%h", lat, {prod_hi, prod_lo}, exp_lat(32'd9), exp);
      end
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL ignore_idle: ready=%b done=%b, want 1 0", ready, done);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || (done_total - d0) != 1) begin
         errors++;
         $display("FAIL ignore_second_start: busy=%b dones=%0d, want 1 1", busy, done_total - d0);
      end
      wait_done(lat, to, bad);
      exp = exp_q.pop_front();
      checks++;
      if (to || lat != exp_lat(32'd2) || {prod_hi, prod_lo} !== exp) begin
         errors++;
         $display("FAIL ignore_second: lat=%0d prod=%h, want lat=%0d prod=%h", lat, {prod_hi, prod_lo}, exp_lat(32'd2), exp);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int lat; bit to; int bad; int d0; logic [63:0] exp;
      issue(32'hDEAD_BEEF, 32'hFFFF_FFFF);
      repeat (10) @(negedge clk);
      d0    = done_total;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || {prod_hi, prod_lo} !== 64'd0 || alu_x !== 32'd0 || alu_y !== 32'd0) begin
         errors++;
         $display("FAIL midreset_outputs: ready=%b busy=%b prod=%h x=%h y=%h", ready, busy, {prod_hi, prod_lo}, alu_x, alu_y);
      end
      exp = exp_q.pop_front();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checks++;
      if (done_total != d0 || ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_nodone: dones=%0d ready=%b, want 0 1", done_total - d0, ready);
      end
      issue(32'h8000_0000, 32'd2);
      wait_done(lat, to, bad);
      exp = exp_q.pop_front();
      checks++;
      if (to || {prod_hi, prod_lo} !== exp || prod_hi !== 32'd1 || prod_lo !== 32'd0) begin
         errors++;
         $display("FAIL midreset_next: got %h (timeout=%b), want %h", {prod_hi, prod_lo}, to, exp);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat; bit to; int bad; logic [63:0] exp;
      logic [31:0] ra, rb;
      for (int n = 0; n < 2000; n++) begin
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
         issue(ra, rb);
         wait_done(lat, to, bad);
         exp = exp_q.pop_front();
         checks++;
         if (to || {prod_hi, prod_lo} !== exp || lat != exp_lat(rb)) begin
            errors++;
            $display("FAIL random_op: a=%h b=%h got %h lat=%0d, want %h lat=%0d", ra, rb, {prod_hi, prod_lo}, lat, exp, exp_lat(rb));
         end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("FAIL random_aluop: %0d cycles with alu_op!=001, want 0", bad);
         end
      end
      @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      done_total = 0;
      test_reset();
      test_basic();
      test_max();
      test_zero();
      test_ignore_start();
      test_reset_mid();
      test_random();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_alu_mul_seq
`default_nettype wire
